// File: rtl/mixcolumns_serial_if.sv
// Byte-stream bundle for the serial MixColumns stage:
// upstream byte input plus downstream byte output.
interface mixcolumns_serial_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       final_round;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_blk_last;

  modport master (
    output in_valid,
    output in_data,
    output final_round,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_last,
    input  out_blk_last
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  final_round,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_last,
    output out_blk_last
  );
endinterface

// File: rtl/mixcolumns_serial.sv
// Byte-serial AES MixColumns with final-round bypass.
// Separate input/output column buffers sustain 1 byte/cycle.
module mixcolumns_serial #(
  parameter int COLS_PER_BLOCK = 4,
  parameter bit BYPASS_EN      = 1'b1
) (
  input logic clk,
  input logic rst_n,
  mixcolumns_serial_if.slave bus
);

  localparam int CW =
    (COLS_PER_BLOCK > 1) ? $clog2(COLS_PER_BLOCK) : 1;
  localparam logic [CW-1:0] COL_MAX =
    CW'(COLS_PER_BLOCK - 1);

  function automatic logic [7:0] xtime(
    input logic [7:0] x
  );
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  logic [3:0][7:0] a_q;
  logic [1:0]      in_cnt_q;
  logic [1:0]      in_cnt_d;
  logic            full_q;
  logic            full_d;
  logic            fr_q;
  logic            fr_d;

  logic [3:0][7:0] r_q;
  logic [1:0]      out_cnt_q;
  logic [1:0]      out_cnt_d;
  logic            out_valid_q;
  logic            out_valid_d;
  logic [CW-1:0]   out_col_q;
  logic [CW-1:0]   out_col_d;

  logic            in_hs;
  logic            out_hs;
  logic            out_byte3;
  logic            drain_done;
  logic            xfer;
  logic            byp;
  logic [3:0][7:0] m2;
  logic [3:0][7:0] m3;
  logic [3:0][7:0] mix;
  logic [3:0][7:0] r_nxt;

  assign in_hs      = bus.in_valid && bus.in_ready;
  assign out_hs     = bus.out_valid && bus.out_ready;
  assign out_byte3  = (out_cnt_q == 2'd3);
  assign drain_done = out_hs && out_byte3;

  // A full column moves across when the out buffer
  // is empty or hands off its last byte this cycle.
  assign xfer = full_q && (!out_valid_q || drain_done);

  // Byte 0 of the next column may enter on the
  // transfer edge; the transfer reads the old a_q.
  assign bus.in_ready = rst_n && (!full_q || xfer);

  assign byp = BYPASS_EN ? fr_q : 1'b0;

  always_comb begin
    m2  = '0;
    m3  = '0;
    mix = '0;
    for (int k = 0; k < 4; k++) begin
      m2[k] = xtime(a_q[k]);
      m3[k] = m2[k] ^ a_q[k];
    end
    mix[0] = m2[0] ^ m3[1] ^ a_q[2] ^ a_q[3];
    mix[1] = a_q[0] ^ m2[1] ^ m3[2] ^ a_q[3];
    mix[2] = a_q[0] ^ a_q[1] ^ m2[2] ^ m3[3];
    mix[3] = m3[0] ^ a_q[1] ^ a_q[2] ^ m2[3];
  end

  assign r_nxt = byp ? a_q : mix;

  always_comb begin
    in_cnt_d = in_cnt_q;
    full_d   = full_q;
    fr_d     = fr_q;
    if (xfer) begin
      full_d = 1'b0;
    end
    if (in_hs) begin
      in_cnt_d = in_cnt_q + 2'd1;
      if (in_cnt_q == 2'd0) begin
        fr_d = bus.final_round;
      end
      if (in_cnt_q == 2'd3) begin
        full_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q      <= '0;
      in_cnt_q <= '0;
      full_q   <= 1'b0;
      fr_q     <= 1'b0;
    end else begin
      if (in_hs) begin
        a_q[in_cnt_q] <= bus.in_data;
      end
      in_cnt_q <= in_cnt_d;
      full_q   <= full_d;
      fr_q     <= fr_d;
    end
  end

  always_comb begin
    out_cnt_d   = out_cnt_q;
    out_valid_d = out_valid_q;
    out_col_d   = out_col_q;
    if (out_hs) begin
      out_cnt_d = out_cnt_q + 2'd1;
      if (out_byte3) begin
        out_valid_d = 1'b0;
        out_col_d   = (out_col_q == COL_MAX)
                      ? '0
                      : out_col_q + CW'(1);
      end
    end
    if (xfer) begin
      out_cnt_d   = 2'd0;
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q         <= '0;
      out_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_col_q   <= '0;
    end else begin
      if (xfer) begin
        r_q <= r_nxt;
      end
      out_cnt_q   <= out_cnt_d;
      out_valid_q <= out_valid_d;
      out_col_q   <= out_col_d;
    end
  end

  assign bus.out_valid    = out_valid_q;
  assign bus.out_data     = r_q[out_cnt_q];
  assign bus.out_last     = out_valid_q && out_byte3;
  assign bus.out_blk_last = bus.out_last
                            && (out_col_q == COL_MAX);

endmodule

// File: tb/tb_mixcolumns_serial.sv
// Bench for mixcolumns_serial: directed AES columns plus
// random traffic against a GF(2^8) matrix reference.
module tb_mixcolumns_serial;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  mixcolumns_serial_if bus();

  mixcolumns_serial #(
    .COLS_PER_BLOCK(4),
    .BYPASS_EN(1'b1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    logic [7:0] d;
    logic       l;
    logic       b;
  } ob_t;

  ob_t        expq[$];
  logic [7:0] mcol[$];
  logic       mfr;
  int         mcolidx = 0;
  logic [7:0] got[$];
  logic       gotl[$];
  logic       gotb[$];
  int         hs_cyc[$];
  int         in3_cyc = 0;
  int         stalls = 0;
  logic       hold_v = 1'b0;
  ob_t        held;
  logic       rdone = 1'b0;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  // Column packed as {a0,a1,a2,a3}, row 0 in the top byte.
  function automatic logic [31:0] mixref(input logic [31:0] col,
                                         input logic fr);
    logic [7:0]  cf [4];
    logic [7:0]  acc;
    logic [31:0] res;
    cf = '{8'h02, 8'h03, 8'h01, 8'h01};
    res = 32'h0;
    if (fr) return col;
    for (int i = 0; i < 4; i++) begin
      acc = 8'h00;
      for (int j = 0; j < 4; j++)
        acc = acc ^ gmul(cf[(j - i) & 3], col[31 - 8*j -: 8]);
      res[31 - 8*i -: 8] = acc;
    end
    return res;
  endfunction

  always @(negedge clk) begin
    ob_t e;
    logic [31:0] c;
    logic [31:0] r;
    if (!rst_n) begin
      expq.delete();
      mcol.delete();
      mcolidx = 0;
      hold_v  = 1'b0;
    end else begin
      if (hold_v) begin
        check("hold_valid", bus.out_valid, 1);
        check("hold_data", bus.out_data, held.d);
        check("hold_last", bus.out_last, held.l);
        check("hold_blk", bus.out_blk_last, held.b);
      end
      hold_v = bus.out_valid && !bus.out_ready;
      held.d = bus.out_data;
      held.l = bus.out_last;
      held.b = bus.out_blk_last;
      if (bus.out_valid && bus.out_ready) begin
        if (expq.size() == 0) begin
          check("unexpected_out", bus.out_valid, 0);
        end else begin
          e = expq.pop_front();
          check("out_data", bus.out_data, e.d);
          check("out_last", bus.out_last, e.l);
          check("out_blk_last", bus.out_blk_last, e.b);
        end
        got.push_back(bus.out_data);
        gotl.push_back(bus.out_last);
        gotb.push_back(bus.out_blk_last);
        hs_cyc.push_back(cyc);
      end
      if (bus.in_valid && bus.in_ready) begin
        if (mcol.size() == 0) mfr = bus.final_round;
        if (mcol.size() == 3) in3_cyc = cyc;
        mcol.push_back(bus.in_data);
        if (mcol.size() == 4) begin
          c = {mcol[0], mcol[1], mcol[2], mcol[3]};
          r = mixref(c, mfr);
          for (int k = 0; k < 4; k++) begin
            e.d = r[31 - 8*k -: 8];
            e.l = (k == 3);
            e.b = (k == 3) && (mcolidx == 3);
            expq.push_back(e);
          end
          mcolidx = (mcolidx + 1) % 4;
          mcol.delete();
        end
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic fr);
    int n;
    n = 0;
    bus.in_valid    = 1'b1;
    bus.in_data     = d;
    bus.final_round = fr;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      stalls++;
      n++;
      if (n > 300) begin
        check("send_timeout", bus.in_ready, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid    = 1'b0;
    bus.final_round = 1'b0;
  endtask

  task automatic send_col(input logic [31:0] col, input logic fr);
    for (int k = 0; k < 4; k++)
      send(col[31 - 8*k -: 8], fr);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (expq.size() != 0 || bus.out_valid) begin
      @(negedge clk);
      n++;
      if (n > 500) begin
        check("drain_timeout", expq.size(), 0);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_got();
    got.delete();
    gotl.delete();
    gotb.delete();
    hs_cyc.delete();
  endtask

  task automatic chk_got(input string nm, input int n,
                         input logic [127:0] exp);
    check({nm, "_count"}, got.size(), n);
    for (int i = 0; i < n; i++)
      if (i < got.size())
        check(nm, got[i], exp[127 - 8*i -: 8]);
  endtask

  task automatic reset_dut();
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 8'h00);
    check("rst_out_last", bus.out_last, 0);
    check("rst_out_blk_last", bus.out_blk_last, 0);
    check("rst_in_ready", bus.in_ready, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_release_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.in_valid    = 1'b0;
    bus.in_data     = 8'h00;
    bus.final_round = 1'b0;
    bus.out_ready   = 1'b1;

    check("model_gmul", gmul(8'h57, 8'h83), 8'hc1);
    check("model_mix_a", mixref(32'hdb135345, 1'b0), 32'h8e4da1bc);
    check("model_mix_b", mixref(32'hf20a225c, 1'b0), 32'h9fdc589d);
    check("model_mix_c", mixref(32'hc6c6c6c6, 1'b0), 32'hc6c6c6c6);
    check("model_mix_d", mixref(32'h01010101, 1'b0), 32'h01010101);
    check("model_byp", mixref(32'hd4bf5d30, 1'b1), 32'hd4bf5d30);

    reset_dut();

    // Single column, latency and out_last placement.
    clear_got();
    send_col(32'hdb135345, 1'b0);
    idle();
    drain();
    chk_got("t1", 4, {32'h8e4da1bc, 96'h0});
    if (hs_cyc.size() > 0)
      check("t1_latency", hs_cyc[0] - in3_cyc, 2);
    if (gotl.size() == 4) begin
      check("t1_last0", gotl[0], 0);
      check("t1_last3", gotl[3], 1);
    end

    // Back-to-back columns at full rate.
    clear_got();
    stalls = 0;
    send_col(32'hf20a225c, 1'b0);
    send_col(32'hc6c6c6c6, 1'b0);
    idle();
    drain();
    chk_got("t2", 8, {64'h9fdc589dc6c6c6c6, 64'h0});
    check("t2_in_stalls", stalls, 0);
    if (hs_cyc.size() == 8)
      check("t2_out_span", hs_cyc[7] - hs_cyc[0], 7);

    // Bypass latched on byte 0 only.
    clear_got();
    send(8'hd4, 1'b1);
    send(8'hbf, 1'b0);
    send(8'h5d, 1'b0);
    send(8'h30, 1'b0);
    idle();
    drain();
    chk_got("t3", 4, {32'hd4bf5d30, 96'h0});

    // Backpressure: hold first result, fill input, stall.
    clear_got();
    bus.out_ready = 1'b0;
    fork
      begin
        send_col(32'hdb135345, 1'b0);
        send_col(32'hdb135345, 1'b0);
        send_col(32'hf20a225c, 1'b0);
        idle();
      end
      begin
        int n;
        n = 0;
        forever begin
          @(negedge clk);
          if (bus.out_valid) break;
          n++;
          if (n > 100) begin
            check("t4_wait_valid", bus.out_valid, 1);
            break;
          end
        end
        repeat (10) @(negedge clk);
        check("t4_held_data", bus.out_data, 8'h8e);
        check("t4_in_blocked", bus.in_ready, 0);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    drain();
    chk_got("t4", 12, {96'h8e4da1bc8e4da1bc9fdc589d, 32'h0});

    // Block boundary marking over two blocks.
    reset_dut();
    clear_got();
    for (int i = 0; i < 32; i++) send(8'h01, 1'b0);
    idle();
    drain();
    check("t5_count", got.size(), 32);
    for (int i = 0; i < 32; i++)
      if (i < gotb.size()) begin
        check("t5_data", got[i], 8'h01);
        check("t5_blk", gotb[i], (i % 16) == 15);
      end

    // Reset mid-column discards the partial bytes.
    send(8'haa, 1'b0);
    send(8'h55, 1'b0);
    reset_dut();
    clear_got();
    send_col(32'hdb135345, 1'b0);
    idle();
    drain();
    chk_got("t6", 4, {32'h8e4da1bc, 96'h0});

    // Random traffic with random gaps and backpressure.
    clear_got();
    rdone = 1'b0;
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          int gap;
          gap = $urandom_range(0, 3);
          if (gap > 1) begin
            idle();
            repeat (gap - 1) @(posedge clk);
            #1;
          end
          send(8'($urandom), ($urandom_range(0, 4) == 0));
        end
        idle();
        rdone = 1'b1;
      end
      begin
        while (!rdone) begin
          @(posedge clk);
          #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();
    check("rand_count", got.size(), 400);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
